// File: rtl/sramc_pkg.sv
// Shared constants and FSM encoding for the SRAM data-phase controller.
// The error states exist only when SRAMC_ERR_RESP_EN is defined.
package sramc_pkg;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

`ifdef SRAMC_ERR_RESP_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
   typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;
`endif

endpackage

// File: rtl/sramc_lane_dec.sv
// Byte-lane decoder: hsize and addr[1:0] -> active byte lanes plus a flag for
// accesses that are misaligned or use an unsupported hsize (treated as word).
module sramc_lane_dec
   import sramc_pkg::*;
(
   input  logic [2:0] hsize_i,
   input  logic [1:0] addr_lo_i,
   output logic [3:0] lane_mask_o,
   output logic       misalign_o
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      lane_mask_o = 4'b1111;
      misalign_o  = 1'b0;
      case (hsize_i)
         HSIZE_BYTE: lane_mask_o = 4'b0001 << addr_lo_i;
         HSIZE_HALF: begin
            lane_mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            misalign_o  = addr_lo_i[0];
         end
         HSIZE_WORD: misalign_o = |addr_lo_i;
         default:    misalign_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/sramc_mem_ctrl.sv
// AHB data-phase stage driving NUM_BANKS x 4 byte-wide synchronous SRAMs.
// Define SRAMC_ERR_RESP_EN to answer illegal accesses with a two-cycle ERROR response.
module sramc_mem_ctrl
   import sramc_pkg::*;
#(
   parameter int AHB_ADDR_WIDTH  = 32,
   parameter int AHB_DATA_WIDTH  = 32,
   parameter int SRAM_ADDR_WIDTH = 13,
   parameter int NUM_BANKS       = 2
)(
   input  logic                       hclk,
   input  logic                       hreset_n,
   input  logic                       hsel_reg,
   input  logic                       hwrite_reg,
   input  logic [2:0]                 hsize_reg,
   input  logic [AHB_ADDR_WIDTH-1:0]  haddr_reg,
   input  logic [AHB_DATA_WIDTH-1:0]  hwdata,
   input  logic [NUM_BANKS*32-1:0]    sram_q,
   output logic [AHB_DATA_WIDTH-1:0]  hrdata,
   output logic                       hready_mem,
   output logic [1:0]                 hresp_mem,
   output logic [NUM_BANKS*4-1:0]     sram_cen,
   output logic                       sram_wen,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]                sram_wdata
);

   localparam int BANK_W    = $clog2(NUM_BANKS);
   localparam int BANK_LSB  = SRAM_ADDR_WIDTH + 2;

   state_t              state_q, state_d;
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic [BANK_W-1:0]   bank;
   logic [3:0]          lane_mask;
   logic                misalign;

   assign bank       = haddr_reg[BANK_LSB +: BANK_W];
   assign sram_addr  = haddr_reg[SRAM_ADDR_WIDTH+1:2];
   assign sram_wdata = hwdata;

   sramc_lane_dec u_lane_dec (
      .hsize_i     (hsize_reg),
      .addr_lo_i   (haddr_reg[1:0]),
      .lane_mask_o (lane_mask),
      .misalign_o  (misalign)
   );

`ifdef SRAMC_ERR_RESP_EN
   localparam int RANGE_LSB = BANK_LSB + BANK_W;
   logic out_of_range;
   logic illegal;

   if (AHB_ADDR_WIDTH > RANGE_LSB) begin : g_range
      assign out_of_range = |haddr_reg[AHB_ADDR_WIDTH-1:RANGE_LSB];
   end else begin : g_no_range
      assign out_of_range = 1'b0;
   end

   assign illegal = misalign | out_of_range;
`else
   // Without error responses the upper address bits wrap and misalignment is ignored.
   logic unused_ok;
   assign unused_ok = &{1'b0, misalign, haddr_reg};
`endif

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q <= ST_IDLE;
         bank_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         state_q <= state_d;
         bank_q  <= bank_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      sram_cen   = '1;
      sram_wen   = 1'b1;
      hready_mem = 1'b1;
      hresp_mem  = HRESP_OKAY;
      hrdata     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (hsel_reg) begin
`ifdef SRAMC_ERR_RESP_EN
               if (illegal) begin
                  hready_mem = 1'b0;
                  hresp_mem  = HRESP_ERROR;
                  state_d    = ST_ERR1;
               end else
`endif
               if (hwrite_reg) begin
                  sram_cen[{bank, 2'b00} +: 4] = ~lane_mask;
                  sram_wen                     = 1'b0;
               end else begin
                  // Reads fetch the whole word; the master picks its lanes.
                  sram_cen[{bank, 2'b00} +: 4] = 4'b0000;
                  hready_mem                   = 1'b0;
                  bank_d                       = bank;
                  state_d                      = ST_RD_WAIT;
               end
            end
         end
         ST_RD_WAIT: begin
            hrdata  = sram_q[{bank_q, 5'b00000} +: 32];
            state_d = ST_IDLE;
         end
`ifdef SRAMC_ERR_RESP_EN
         ST_ERR1: begin
            hresp_mem = HRESP_ERROR;
            state_d   = ST_ERR2;
         end
         ST_ERR2: state_d = ST_IDLE;
`endif
      endcase
   end

endmodule

// File: tb/tb_sramc_mem_ctrl.sv
// Self-checking bench for sramc_mem_ctrl: directed cases then random transfers,
// checked against a byte-addressed reference memory and an SRAM array model.
`timescale 1ns/1ps
module tb_sramc_mem_ctrl;

   localparam int NB        = 2;
   localparam int SAW       = 13;
   localparam int MEM_BYTES = NB * (1 << (SAW + 2));

   logic              hclk = 1'b0;
   logic              hreset_n;
   logic              hsel_reg;
   logic              hwrite_reg;
   logic [2:0]        hsize_reg;
   logic [31:0]       haddr_reg;
   logic [31:0]       hwdata;
   logic [NB*32-1:0]  sram_q;
   logic [31:0]       hrdata;
   logic              hready_mem;
   logic [1:0]        hresp_mem;
   logic [NB*4-1:0]   sram_cen;
   logic              sram_wen;
   logic [SAW-1:0]    sram_addr;
   logic [31:0]       sram_wdata;

   int n_vec = 0;
   int n_err = 0;

   bit [7:0] sram_mem [NB][4][1 << SAW];
   bit [7:0] sram_rd  [NB][4];
   bit [7:0] ref_mem  [MEM_BYTES];

   sramc_mem_ctrl dut (
      .hclk       (hclk),
      .hreset_n   (hreset_n),
      .hsel_reg   (hsel_reg),
      .hwrite_reg (hwrite_reg),
      .hsize_reg  (hsize_reg),
      .haddr_reg  (haddr_reg),
      .hwdata     (hwdata),
      .sram_q     (sram_q),
      .hrdata     (hrdata),
      .hready_mem (hready_mem),
      .hresp_mem  (hresp_mem),
      .sram_cen   (sram_cen),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata)
   );

   always #5 hclk = ~hclk;

   // Byte-wide synchronous SRAM macros, one per bank/lane.
   always @(posedge hclk) begin
      for (int b = 0; b < NB; b++) begin
         for (int l = 0; l < 4; l++) begin
            if (!sram_cen[4*b+l]) begin
               if (!sram_wen) sram_mem[b][l][sram_addr] <= sram_wdata[8*l +: 8];
               else           sram_rd[b][l] <= sram_mem[b][l][sram_addr];
            end
         end
      end
   end

   always_comb begin
      sram_q = '0;
      for (int b = 0; b < NB; b++)
         for (int l = 0; l < 4; l++)
            sram_q[32*b+8*l +: 8] = sram_rd[b][l];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_cycle();
      hsel_reg   = 1'b0;
      hwrite_reg = 1'($urandom);
      haddr_reg  = $urandom;
      @(negedge hclk);
      check("idle_ready", hready_mem, 1);
      check("idle_resp",  hresp_mem,  0);
      check("idle_cen",   sram_cen,   8'hFF);
      check("idle_rdata", hrdata,     0);
      step();
   endtask

   // One complete transfer: expectations come from the access rules, not the DUT.
   task automatic xfer(input bit wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      int unsigned n, base, bnk, w;
      logic [7:0]  cen_exp;
      logic [31:0] rd_exp;
      bit          ill;
      hsel_reg   = 1'b1;
      hwrite_reg = wr;
      hsize_reg  = sz;
      haddr_reg  = a;
      hwdata     = d;
      n    = (sz >= 3'd2) ? 4 : (1 << sz);
      base = (a & ~(n - 1)) % MEM_BYTES;
      bnk  = base >> (SAW + 2);
`ifdef SRAMC_ERR_RESP_EN
      ill = (sz > 3'd2) || (a % n != 0) || (a >= MEM_BYTES);
`else
      ill = 1'b0;
`endif
      if (ill) begin
         @(negedge hclk);
         check("err1_ready", hready_mem, 0);
         check("err1_resp",  hresp_mem,  1);
         check("err1_cen",   sram_cen,   8'hFF);
         step();
         @(negedge hclk);
         check("err2_ready", hready_mem, 1);
         check("err2_resp",  hresp_mem,  1);
         check("err2_cen",   sram_cen,   8'hFF);
         step();
         @(negedge hclk);
         check("err3_ready", hready_mem, 1);
         check("err3_cen",   sram_cen,   8'hFF);
         step();
         return;
      end
      cen_exp = 8'hFF;
      if (wr) begin
         for (int i = 0; i < int'(n); i++) cen_exp[bnk*4 + (base + i) % 4] = 1'b0;
      end else begin
         cen_exp[bnk*4 +: 4] = 4'b0000;
      end
      @(negedge hclk);
      check(wr ? "wr_ready" : "rd_ready", hready_mem, wr ? 1 : 0);
      check(wr ? "wr_resp"  : "rd_resp",  hresp_mem,  0);
      check(wr ? "wr_cen"   : "rd_cen",   sram_cen,   cen_exp);
      check(wr ? "wr_wen"   : "rd_wen",   sram_wen,   wr ? 0 : 1);
      check(wr ? "wr_addr"  : "rd_addr",  sram_addr,  (a >> 2) & ((1 << SAW) - 1));
      if (wr) begin
         check("wr_wdata", sram_wdata, d);
         for (int i = 0; i < int'(n); i++) ref_mem[base + i] = d[8*((base + i) % 4) +: 8];
         step();
         return;
      end
      w      = base & ~32'd3;
      rd_exp = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      step();
      @(negedge hclk);
      check("rd_data",   hrdata,     rd_exp);
      check("rd2_ready", hready_mem, 1);
      check("rd2_resp",  hresp_mem,  0);
      check("rd2_cen",   sram_cen,   8'hFF);
      step();
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  sz;
      hreset_n   = 1'b0;
      hsel_reg   = 1'b0;
      hwrite_reg = 1'b0;
      hsize_reg  = 3'd0;
      haddr_reg  = '0;
      hwdata     = '0;
      repeat (2) @(negedge hclk);
      check("rst_cen",   sram_cen,   8'hFF);
      check("rst_wen",   sram_wen,   1);
      check("rst_ready", hready_mem, 1);
      check("rst_resp",  hresp_mem,  0);
      check("rst_rdata", hrdata,     0);
      hreset_n = 1'b1;
      step();

      xfer(1, 3'd2, 32'h0000_0010, 32'h1234_5678);
      xfer(0, 3'd2, 32'h0000_0010, 32'h0);
      xfer(1, 3'd0, 32'h0000_8003, 32'hAB00_0000);
      xfer(1, 3'd1, 32'h0000_0002, 32'hCAFE_0000);
      xfer(0, 3'd2, 32'h0000_8000, 32'h0);
      xfer(0, 3'd2, 32'h0000_0000, 32'h0);
      xfer(1, 3'd2, 32'h0000_0002, 32'hDEAD_BEEF);
      xfer(0, 3'd2, 32'h0000_0000, 32'h0);
      xfer(1, 3'd2, 32'h0001_0010, 32'h0BAD_F00D);
      xfer(1, 3'd3, 32'h0000_0004, 32'h5555_AAAA);
      xfer(0, 3'd2, 32'h0000_0010, 32'h0);
      xfer(0, 3'd2, 32'h0000_0004, 32'h0);
      idle_cycle();

      // Reset asserted while the read wait state is in progress.
      hsel_reg   = 1'b1;
      hwrite_reg = 1'b0;
      hsize_reg  = 3'd2;
      haddr_reg  = 32'h0000_0010;
      @(negedge hclk);
      check("abort_rd_ready", hready_mem, 0);
      step();
      hsel_reg = 1'b0;
      hreset_n = 1'b0;
      #1;
      check("abort_ready", hready_mem, 1);
      check("abort_cen",   sram_cen,   8'hFF);
      check("abort_rdata", hrdata,     0);
      check("abort_resp",  hresp_mem,  0);
      @(negedge hclk);
      hreset_n = 1'b1;
      step();
      xfer(0, 3'd2, 32'h0000_0010, 32'h0);

      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle_cycle();
         end else begin
            a = ($urandom_range(0, 1) << 15) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(16, 31));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xfer(1'($urandom), sz, a, $urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
